// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the execute stage: one-hot op bit indices, bus widths,
// divider state encoding and a small magnitude helper.
package cpu_defs_pkg;

  localparam int unsigned DIV_W    = 32;
  localparam int unsigned ALU_OPS  = 12;
  localparam int unsigned MD_OPS   = 7;
  localparam int unsigned RF_ZIP_W = 6;
  localparam int unsigned ES_ZIP_W = 39;

  // ALU one-hot bit positions
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLT  = 2;
  localparam int unsigned OP_SLTU = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_XOR  = 7;
  localparam int unsigned OP_SLL  = 8;
  localparam int unsigned OP_SRL  = 9;
  localparam int unsigned OP_SRA  = 10;
  localparam int unsigned OP_LUI  = 11;

  // Mul/div one-hot bit positions
  localparam int unsigned MD_MUL   = 0;
  localparam int unsigned MD_MULH  = 1;
  localparam int unsigned MD_MULHU = 2;
  localparam int unsigned MD_DIV   = 3;
  localparam int unsigned MD_MOD   = 4;
  localparam int unsigned MD_DIVU  = 5;
  localparam int unsigned MD_MODU  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Magnitude of x when treated as signed, raw value otherwise.
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] x, input logic sgn);
    return (sgn && x[DIV_W-1]) ? DIV_W'(-x) : x;
  endfunction

endpackage

// File: rtl/div32_iter.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Ports: clk/resetn; start launches a divide from IDLE with signed_op, dividend,
// divisor; busy while iterating; done holds quotient/remainder until ack.
module div32_iter
  import cpu_defs_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  div_state_t       state;
  logic [4:0]       count;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] dvs_q;
  logic             q_neg;
  logic             r_neg;
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W:0]   diff;

  // Trial subtraction; diff[DIV_W] set means the partial remainder is smaller than the divisor.
  always_comb begin
    rem_sh = {rem_q, quo_q[DIV_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      count <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state <= DIV_BUSY;
            count <= '0;
            rem_q <= '0;
            quo_q <= abs_val(dividend, signed_op);
            dvs_q <= abs_val(divisor, signed_op);
            q_neg <= signed_op & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
            r_neg <= signed_op & dividend[DIV_W-1];
          end
        end
        DIV_BUSY: begin
          quo_q <= {quo_q[DIV_W-2:0], ~diff[DIV_W]};
          rem_q <= diff[DIV_W] ? rem_sh[DIV_W-1:0] : diff[DIV_W-1:0];
          count <= count + 5'd1;
          if (count == 5'd31) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = q_neg ? DIV_W'(-quo_q) : quo_q;
  assign remainder = r_neg ? DIV_W'(-rem_q) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: registers one decoded instruction, computes ALU / multiply /
// iterative divide results, issues the data SRAM request in the handoff cycle and
// presents the writeback payload and a bypass bus.
// Ports: clk, resetn (sync, active low); decode side ds2es_valid/es_allowin and ds_*
// payload; mem side es2ms_valid/ms_allowin, es_pc, es_rf_zip; es_fwd to decode;
// data_sram_* request.
module exe_stage
  import cpu_defs_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ds2es_valid,
  output logic                es_allowin,
  input  logic [31:0]         ds_pc,
  input  logic [ALU_OPS-1:0]  ds_alu_op,
  input  logic [MD_OPS-1:0]   ds_md_op,
  input  logic [31:0]         ds_src1,
  input  logic [31:0]         ds_src2,
  input  logic                ds_mem_en,
  input  logic                ds_mem_we,
  input  logic [31:0]         ds_store_data,
  input  logic                ds_res_from_mem,
  input  logic [RF_ZIP_W-1:0] ds_rf_zip,
  output logic                es2ms_valid,
  input  logic                ms_allowin,
  output logic [31:0]         es_pc,
  output logic [ES_ZIP_W-1:0] es_rf_zip,
  output logic [ES_ZIP_W-1:0] es_fwd,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata
);

  logic               es_valid;
  logic [ALU_OPS-1:0] alu_op;
  logic [MD_OPS-1:0]  md_op;
  logic [31:0]        src1;
  logic [31:0]        src2;
  logic               mem_en;
  logic               mem_we;
  logic [31:0]        store_data;
  logic               res_from_mem;
  logic               rf_we;
  logic [4:0]         rf_waddr;

  logic               is_div;
  logic               es_ready_go;
  logic               div_busy;
  logic               div_done;
  logic [31:0]        div_q;
  logic [31:0]        div_r;
  logic [31:0]        alu_res;
  logic [32:0]        mul_a;
  logic [32:0]        mul_b;
  logic [63:0]        mul_prod;
  logic [31:0]        es_result;

  // Valid and payload registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid     <= 1'b0;
      es_pc        <= '0;
      alu_op       <= '0;
      md_op        <= '0;
      src1         <= '0;
      src2         <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      store_data   <= '0;
      res_from_mem <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
    end else begin
      if (es_allowin) es_valid <= ds2es_valid;
      if (ds2es_valid && es_allowin) begin
        es_pc        <= ds_pc;
        alu_op       <= ds_alu_op;
        md_op        <= ds_md_op;
        src1         <= ds_src1;
        src2         <= ds_src2;
        mem_en       <= ds_mem_en;
        mem_we       <= ds_mem_we;
        store_data   <= ds_store_data;
        res_from_mem <= ds_res_from_mem;
        rf_we        <= ds_rf_zip[5];
        rf_waddr     <= ds_rf_zip[4:0];
      end
    end
  end

  assign is_div      = md_op[MD_DIV] | md_op[MD_MOD] | md_op[MD_DIVU] | md_op[MD_MODU];
  assign es_ready_go = ~is_div | div_done;
  assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
  assign es2ms_valid = es_valid & es_ready_go;

  div32_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (es_valid & is_div & ~div_busy & ~div_done),
    .signed_op (md_op[MD_DIV] | md_op[MD_MOD]),
    .dividend  (src1),
    .divisor   (src2),
    .ack       (es2ms_valid & ms_allowin),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // One-hot ALU: AND-OR select of every candidate result
  always_comb begin
    alu_res = '0;
    if (alu_op[OP_ADD])  alu_res = alu_res | (src1 + src2);
    if (alu_op[OP_SUB])  alu_res = alu_res | (src1 - src2);
    if (alu_op[OP_SLT])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[OP_SLTU]) alu_res = alu_res | {31'd0, src1 < src2};
    if (alu_op[OP_AND])  alu_res = alu_res | (src1 & src2);
    if (alu_op[OP_NOR])  alu_res = alu_res | ~(src1 | src2);
    if (alu_op[OP_OR])   alu_res = alu_res | (src1 | src2);
    if (alu_op[OP_XOR])  alu_res = alu_res | (src1 ^ src2);
    if (alu_op[OP_SLL])  alu_res = alu_res | (src1 << src2[4:0]);
    if (alu_op[OP_SRL])  alu_res = alu_res | (src1 >> src2[4:0]);
    if (alu_op[OP_SRA])  alu_res = alu_res | 32'($signed(src1) >>> src2[4:0]);
    if (alu_op[OP_LUI])  alu_res = alu_res | src2;
  end

  // 33x33 signed multiply; the 64-bit truncated product is exact for both high and low halves.
  assign mul_a    = {~md_op[MD_MULHU] & src1[31], src1};
  assign mul_b    = {~md_op[MD_MULHU] & src2[31], src2};
  assign mul_prod = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  always_comb begin
    es_result = alu_res;
    if (md_op[MD_MUL])                   es_result = mul_prod[31:0];
    if (md_op[MD_MULH] | md_op[MD_MULHU]) es_result = mul_prod[63:32];
    if (md_op[MD_DIV] | md_op[MD_DIVU])   es_result = div_q;
    if (md_op[MD_MOD] | md_op[MD_MODU])   es_result = div_r;
  end

  assign es_rf_zip       = {res_from_mem, es_valid & rf_we, rf_waddr, es_result};
  assign es_fwd          = {es_valid & rf_we, rf_waddr, es_result, res_from_mem};
  assign data_sram_en    = es_valid & mem_en & es_ready_go & ms_allowin;
  assign data_sram_we    = {4{data_sram_en & mem_we}};
  assign data_sram_addr  = es_result;
  assign data_sram_wdata = store_data;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage.
module tb_exe_stage;
  import cpu_defs_pkg::*;

  logic                clk = 1'b0;
  logic                resetn;
  logic                ds2es_valid;
  logic                es_allowin;
  logic [31:0]         ds_pc;
  logic [ALU_OPS-1:0]  ds_alu_op;
  logic [MD_OPS-1:0]   ds_md_op;
  logic [31:0]         ds_src1;
  logic [31:0]         ds_src2;
  logic                ds_mem_en;
  logic                ds_mem_we;
  logic [31:0]         ds_store_data;
  logic                ds_res_from_mem;
  logic [RF_ZIP_W-1:0] ds_rf_zip;
  logic                es2ms_valid;
  logic                ms_allowin;
  logic [31:0]         es_pc;
  logic [ES_ZIP_W-1:0] es_rf_zip;
  logic [ES_ZIP_W-1:0] es_fwd;
  logic                data_sram_en;
  logic [3:0]          data_sram_we;
  logic [31:0]         data_sram_addr;
  logic [31:0]         data_sram_wdata;

  int compared   = 0;
  int mismatched = 0;
  int cnt;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds2es_valid     (ds2es_valid),
    .es_allowin      (es_allowin),
    .ds_pc           (ds_pc),
    .ds_alu_op       (ds_alu_op),
    .ds_md_op        (ds_md_op),
    .ds_src1         (ds_src1),
    .ds_src2         (ds_src2),
    .ds_mem_en       (ds_mem_en),
    .ds_mem_we       (ds_mem_we),
    .ds_store_data   (ds_store_data),
    .ds_res_from_mem (ds_res_from_mem),
    .ds_rf_zip       (ds_rf_zip),
    .es2ms_valid     (es2ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_rf_zip       (es_rf_zip),
    .es_fwd          (es_fwd),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [11:0] alu, input logic [6:0] md,
                       input logic [31:0] s1, input logic [31:0] s2, input logic men,
                       input logic mwe, input logic [31:0] sd, input logic rfm,
                       input logic [5:0] zip);
    ds2es_valid     = 1'b1;
    ds_pc           = pc;
    ds_alu_op       = alu;
    ds_md_op        = md;
    ds_src1         = s1;
    ds_src2         = s2;
    ds_mem_en       = men;
    ds_mem_we       = mwe;
    ds_store_data   = sd;
    ds_res_from_mem = rfm;
    ds_rf_zip       = zip;
  endtask

  // Single-cycle ALU instruction; result checked in its handoff cycle.
  task automatic run_alu(input string tag, input int unsigned idx, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp);
    issue(32'h2000, 12'(1) << idx, 7'd0, s1, s2, 1'b0, 1'b0, 32'd0, 1'b0, 6'h22);
    next();
    ds2es_valid = 1'b0;
    #1;
    chk(tag, 64'(es_rf_zip[31:0]), 64'(exp));
    chk({tag, "_valid"}, 64'(es2ms_valid), 64'd1);
  endtask

  // Mul/div instruction; checks stall length before handoff and the result.
  task automatic run_md(input string tag, input int unsigned idx, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] exp, input int lat);
    int c;
    issue(32'h3000, 12'd0, 7'(1) << idx, s1, s2, 1'b0, 1'b0, 32'd0, 1'b0, 6'h23);
    next();
    ds2es_valid = 1'b0;
    c = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (es_allowin) break;
      c++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, 64'(c), 64'(lat));
    chk(tag, 64'(es_rf_zip[31:0]), 64'(exp));
    chk({tag, "_valid"}, 64'(es2ms_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    ms_allowin = 1'b1;
    issue(32'd0, 12'd0, 7'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 6'd0);
    ds2es_valid = 1'b0;
    next();
    next();
    #1;
    chk("rst_allowin", 64'(es_allowin), 64'd1);
    chk("rst_valid", 64'(es2ms_valid), 64'd0);
    chk("rst_pc", 64'(es_pc), 64'd0);
    chk("rst_zip", 64'(es_rf_zip), 64'd0);
    chk("rst_fwd", 64'(es_fwd), 64'd0);
    chk("rst_sram_en", 64'(data_sram_en), 64'd0);
    resetn = 1'b1;
    next();

    // add 5+7 with a one-cycle handoff
    issue(32'h1000, 12'(1) << OP_ADD, 7'd0, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, {1'b1, 5'd3});
    next();
    ds2es_valid = 1'b0;
    #1;
    chk("add_valid", 64'(es2ms_valid), 64'd1);
    chk("add_zip", 64'(es_rf_zip), 64'({1'b0, 1'b1, 5'd3, 32'd12}));
    chk("add_fwd", 64'(es_fwd), 64'({1'b1, 5'd3, 32'd12, 1'b0}));
    chk("add_pc", 64'(es_pc), 64'h1000);
    chk("add_sram_en", 64'(data_sram_en), 64'd0);
    next();
    #1;
    chk("add_valid_drop", 64'(es2ms_valid), 64'd0);

    // Back-to-back ALU ops
    run_alu("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_alu("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_alu("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_alu("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    run_alu("nor", OP_NOR, 32'h0000_0000, 32'h0000_00FF, 32'hFFFF_FF00);
    run_alu("or", OP_OR, 32'hA000_0001, 32'h0500_0010, 32'hA500_0011);
    run_alu("xor", OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
    run_alu("sll", OP_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000);
    run_alu("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    run_alu("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run_alu("lui", OP_LUI, 32'hDEAD_BEEF, 32'h1234_0000, 32'h1234_0000);

    // Multiplies complete with no stall
    run_md("mul", MD_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0);
    run_md("mulh", MD_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 0);
    run_md("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);

    // Store: request only in the handoff cycle
    issue(32'h1100, 12'(1) << OP_ADD, 7'd0, 32'h0F0, 32'h010, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 6'd0);
    next();
    ds2es_valid = 1'b0;
    #1;
    chk("st_en", 64'(data_sram_en), 64'd1);
    chk("st_we", 64'(data_sram_we), 64'hF);
    chk("st_addr", 64'(data_sram_addr), 64'h100);
    chk("st_wdata", 64'(data_sram_wdata), 64'hA5A5_A5A5);
    next();
    #1;
    chk("st_en_drop", 64'(data_sram_en), 64'd0);
    chk("st_we_drop", 64'(data_sram_we), 64'h0);

    // Divides, back to back, including boundary cases
    run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_md("mod_neg", MD_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_md("divu_z", MD_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 33);
    run_md("modu_z", MD_MODU, 32'd10, 32'd0, 32'd10, 33);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_md("mod_ovf", MD_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    next();
    #1;
    chk("div_valid_drop", 64'(es2ms_valid), 64'd0);

    // Load add stalled by mem stage for 5 cycles
    ms_allowin = 1'b0;
    issue(32'h1200, 12'(1) << OP_ADD, 7'd0, 32'd3, 32'd4, 1'b1, 1'b0, 32'd0, 1'b1, {1'b1, 5'd9});
    next();
    ds2es_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 64'(es2ms_valid), 64'd1);
      chk("stall_sram_en", 64'(data_sram_en), 64'd0);
      chk("stall_allowin", 64'(es_allowin), 64'd0);
      chk("stall_res", 64'(es_rf_zip[31:0]), 64'd7);
      next();
    end
    ms_allowin = 1'b1;
    #1;
    chk("stall_go_en", 64'(data_sram_en), 64'd1);
    chk("stall_go_we", 64'(data_sram_we), 64'h0);
    chk("stall_go_zip", 64'(es_rf_zip), 64'({1'b1, 1'b1, 5'd9, 32'd7}));
    next();
    #1;
    chk("stall_drop_valid", 64'(es2ms_valid), 64'd0);
    chk("stall_drop_en", 64'(data_sram_en), 64'd0);

    // Divide held in DONE while mem stage stalls
    next();
    issue(32'h1300, 12'd0, 7'(1) << MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 32'd0, 1'b0, {1'b1, 5'd4});
    next();
    ds2es_valid = 1'b0;
    ms_allowin = 1'b0;
    cnt = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (es2ms_valid) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("done_lat", 64'(cnt), 64'd33);
    for (int i = 0; i < 5; i++) begin
      chk("done_hold_valid", 64'(es2ms_valid), 64'd1);
      chk("done_hold_res", 64'(es_rf_zip[31:0]), 64'd14);
      chk("done_hold_en", 64'(data_sram_en), 64'd0);
      @(posedge clk);
      #1;
    end
    ms_allowin = 1'b1;
    #1;
    chk("done_go_en", 64'(data_sram_en), 64'd1);
    chk("done_go_res", 64'(es_rf_zip[31:0]), 64'd14);
    next();
    #1;
    chk("done_drop_valid", 64'(es2ms_valid), 64'd0);
    chk("done_drop_en", 64'(data_sram_en), 64'd0);

    // Reset in the middle of a divide, then a fresh divide
    issue(32'h1400, 12'd0, 7'(1) << MD_DIV, 32'd50, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0, {1'b1, 5'd5});
    next();
    ds2es_valid = 1'b0;
    repeat (11) next();
    resetn = 1'b0;
    next();
    #1;
    chk("mid_rst_allowin", 64'(es_allowin), 64'd1);
    chk("mid_rst_valid", 64'(es2ms_valid), 64'd0);
    chk("mid_rst_zip", 64'(es_rf_zip), 64'd0);
    resetn = 1'b1;
    run_md("div_after_rst", MD_DIV, 32'd100, 32'd7, 32'd14, 33);
    run_md("mod_after_rst", MD_MOD, 32'd100, 32'd7, 32'd2, 33);
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
